// File: rtl/bram_blocks_seq_rw_if.sv
`default_nettype none
// ============================================================================
// Module : bram_blocks_seq_rw_if
// Desc   : Read/write sequencer command and data bundle for bram_blocks_seq_rw.
// Rev    : 1.0
// ============================================================================
interface bram_blocks_seq_rw_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
);
  localparam int c_AW = $clog2(NUM_BLOCKS);
  localparam int c_CW = $clog2(NUM_BLOCKS + 1);

  logic                     read_start_in;
  logic [c_AW-1:0]          read_base_in;
  logic [c_CW-1:0]          read_len_in;
  logic                     read_next_block_valid_in;
  logic [REGISTER_SIZE-1:0] read_block_out;
  logic                     read_block_valid_out;
  logic                     read_last_block_out;
  logic                     read_busy_out;
  logic                     read_overrun_out;

  logic                     write_start_in;
  logic [c_AW-1:0]          write_base_in;
  logic [c_CW-1:0]          write_len_in;
  logic                     write_next_block_valid_in;
  logic [REGISTER_SIZE-1:0] write_block_in;
  logic                     write_last_out;
  logic                     write_busy_out;
  logic                     write_overrun_out;

  modport master (
    output read_start_in, read_base_in, read_len_in, read_next_block_valid_in,
    input  read_block_out, read_block_valid_out, read_last_block_out,
    input  read_busy_out, read_overrun_out,
    output write_start_in, write_base_in, write_len_in,
    output write_next_block_valid_in, write_block_in,
    input  write_last_out, write_busy_out, write_overrun_out
  );

  modport slave (
    input  read_start_in, read_base_in, read_len_in, read_next_block_valid_in,
    output read_block_out, read_block_valid_out, read_last_block_out,
    output read_busy_out, read_overrun_out,
    input  write_start_in, write_base_in, write_len_in,
    input  write_next_block_valid_in, write_block_in,
    output write_last_out, write_busy_out, write_overrun_out
  );
endinterface
`default_nettype wire

// File: rtl/bram_blocks_seq_rw.sv
`default_nettype none
// ============================================================================
// Module : bram_blocks_seq_rw
// Desc   : Independent sequential read/write block sequencers over a dual-port RAM.
// Rev    : 1.0
// ============================================================================
module bram_blocks_seq_rw #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int READ_LATENCY  = 2,
  parameter     INIT_FILE     = ""
) (
  input wire logic            clk_in,
  input wire logic            rst_n_in,
  bram_blocks_seq_rw_if.slave bus
);
  localparam int              c_AW        = $clog2(NUM_BLOCKS);
  localparam int              c_CW        = $clog2(NUM_BLOCKS + 1);
  localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(NUM_BLOCKS - 1);
  localparam logic [c_CW-1:0] c_MAX_LEN   = c_CW'(NUM_BLOCKS);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} seq_state_t;

  function automatic logic [c_AW-1:0] f_next_addr(input logic [c_AW-1:0] a);
    return (a == c_LAST_ADDR) ? '0 : a + c_AW'(1);
  endfunction

  function automatic logic [c_CW-1:0] f_clamp(input logic [c_CW-1:0] len);
    return (len > c_MAX_LEN) ? c_MAX_LEN : len;
  endfunction

  logic [REGISTER_SIZE-1:0] r_mem [NUM_BLOCKS];

  // Release of the async reset is retimed so no request lands on the release edge.
  logic [1:0] r_rst_sync;
  logic       r_ready;
  assign r_ready = r_rst_sync[1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // ---------------- read sequencer ----------------
  seq_state_t      r_rd_state, w_rd_state_nxt;
  logic [c_AW-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [c_CW-1:0] r_rd_rem, w_rd_rem_nxt;
  logic            r_rd_ovr, w_rd_ovr_nxt;
  logic            w_rd_accept, w_rd_accept_last;

  always_comb begin
    w_rd_state_nxt   = r_rd_state;
    w_rd_addr_nxt    = r_rd_addr;
    w_rd_rem_nxt     = r_rd_rem;
    w_rd_ovr_nxt     = r_rd_ovr;
    w_rd_accept      = 1'b0;
    w_rd_accept_last = 1'b0;
    if (r_ready) begin
      if (bus.read_start_in && (bus.read_len_in != '0)) begin
        w_rd_state_nxt = S_BUSY;
        w_rd_addr_nxt  = bus.read_base_in;
        w_rd_rem_nxt   = f_clamp(bus.read_len_in);
        w_rd_ovr_nxt   = 1'b0;
      end else if (bus.read_next_block_valid_in) begin
        if (r_rd_state == S_BUSY) begin
          w_rd_accept      = 1'b1;
          w_rd_accept_last = (r_rd_rem == c_ONE);
          w_rd_addr_nxt    = f_next_addr(r_rd_addr);
          w_rd_rem_nxt     = r_rd_rem - c_ONE;
          if (r_rd_rem == c_ONE) w_rd_state_nxt = S_IDLE;
        end else begin
          w_rd_ovr_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_state <= S_IDLE;
      r_rd_addr  <= '0;
      r_rd_rem   <= '0;
      r_rd_ovr   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_rd_rem   <= w_rd_rem_nxt;
      r_rd_ovr   <= w_rd_ovr_nxt;
    end
  end

  // Each stage only loads behind a valid, so the last stage holds the last read word.
  logic [REGISTER_SIZE-1:0] r_pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0]  r_pipe_valid;
  logic [READ_LATENCY-1:0]  r_pipe_last;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pipe_valid <= '0;
      r_pipe_last  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_valid[0] <= w_rd_accept;
      r_pipe_last[0]  <= w_rd_accept_last;
      if (w_rd_accept) r_pipe_data[0] <= r_mem[r_rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_last[i]  <= r_pipe_last[i-1];
        if (r_pipe_valid[i-1]) r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign bus.read_block_out       = r_pipe_data[READ_LATENCY-1];
  assign bus.read_block_valid_out = r_pipe_valid[READ_LATENCY-1];
  assign bus.read_last_block_out  = r_pipe_last[READ_LATENCY-1];
  assign bus.read_busy_out        = (r_rd_state == S_BUSY);
  assign bus.read_overrun_out     = r_rd_ovr;

  // ---------------- write sequencer ----------------
  seq_state_t      r_wr_state, w_wr_state_nxt;
  logic [c_AW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [c_CW-1:0] r_wr_rem, w_wr_rem_nxt;
  logic            r_wr_ovr, w_wr_ovr_nxt;
  logic            w_wr_accept, w_wr_accept_last;
  logic            r_wr_last;

  always_comb begin
    w_wr_state_nxt   = r_wr_state;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_rem_nxt     = r_wr_rem;
    w_wr_ovr_nxt     = r_wr_ovr;
    w_wr_accept      = 1'b0;
    w_wr_accept_last = 1'b0;
    if (r_ready) begin
      if (bus.write_start_in && (bus.write_len_in != '0)) begin
        w_wr_state_nxt = S_BUSY;
        w_wr_addr_nxt  = bus.write_base_in;
        w_wr_rem_nxt   = f_clamp(bus.write_len_in);
        w_wr_ovr_nxt   = 1'b0;
      end else if (bus.write_next_block_valid_in) begin
        if (r_wr_state == S_BUSY) begin
          w_wr_accept      = 1'b1;
          w_wr_accept_last = (r_wr_rem == c_ONE);
          w_wr_addr_nxt    = f_next_addr(r_wr_addr);
          w_wr_rem_nxt     = r_wr_rem - c_ONE;
          if (r_wr_rem == c_ONE) w_wr_state_nxt = S_IDLE;
        end else begin
          w_wr_ovr_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_state <= S_IDLE;
      r_wr_addr  <= '0;
      r_wr_rem   <= '0;
      r_wr_ovr   <= 1'b0;
      r_wr_last  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_rem   <= w_wr_rem_nxt;
      r_wr_ovr   <= w_wr_ovr_nxt;
      r_wr_last  <= w_wr_accept_last;
    end
  end

  // Memory has no reset; the port-A read above samples the pre-write contents.
  always_ff @(posedge clk_in) begin
    if (w_wr_accept) r_mem[r_wr_addr] <= bus.write_block_in;
  end

  assign bus.write_last_out    = r_wr_last;
  assign bus.write_busy_out    = (r_wr_state == S_BUSY);
  assign bus.write_overrun_out = r_wr_ovr;

endmodule
`default_nettype wire

// File: tb/tb_bram_blocks_seq_rw.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_blocks_seq_rw
// Desc   : Directed self-checking bench for bram_blocks_seq_rw.
// Rev    : 1.0
// ============================================================================
module tb_bram_blocks_seq_rw;
  localparam int c_RS = 32;
  localparam int c_NB = 128;
  localparam int c_AW = $clog2(c_NB);
  localparam int c_CW = $clog2(c_NB + 1);

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  bram_blocks_seq_rw_if #(.REGISTER_SIZE(c_RS), .NUM_BLOCKS(c_NB)) bus ();

  bram_blocks_seq_rw #(
    .REGISTER_SIZE(c_RS),
    .NUM_BLOCKS   (c_NB),
    .READ_LATENCY (2),
    .INIT_FILE    ("")
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_burst(input int base, input int len, input logic [31:0] d [4]);
    bus.write_start_in = 1'b1;
    bus.write_base_in  = c_AW'(base);
    bus.write_len_in   = c_CW'(len);
    step();
    bus.write_start_in = 1'b0;
    check("wr_busy_start", bus.write_busy_out, 1);
    check("wr_ovr_clear", bus.write_overrun_out, 0);
    for (int k = 0; k < len; k++) begin
      bus.write_next_block_valid_in = 1'b1;
      bus.write_block_in            = d[k];
      step();
      check("wr_last", bus.write_last_out, (k == len - 1));
    end
    bus.write_next_block_valid_in = 1'b0;
    check("wr_busy_end", bus.write_busy_out, 0);
    step();
    check("wr_last_drop", bus.write_last_out, 0);
  endtask

  task automatic read_burst(input int base, input int len, input logic [31:0] d [4]);
    bit exp_v;
    bus.read_start_in = 1'b1;
    bus.read_base_in  = c_AW'(base);
    bus.read_len_in   = c_CW'(len);
    step();
    bus.read_start_in = 1'b0;
    check("rd_busy_start", bus.read_busy_out, 1);
    check("rd_ovr_clear", bus.read_overrun_out, 0);
    for (int k = 0; k < len + 2; k++) begin
      bus.read_next_block_valid_in = (k < len);
      step();
      exp_v = (k >= 1) && (k <= len);
      check("rd_valid", bus.read_block_valid_out, exp_v);
      check("rd_last", bus.read_last_block_out, (k == len));
      if (exp_v) check("rd_data", bus.read_block_out, d[k-1]);
      if (k == len + 1) check("rd_data_hold", bus.read_block_out, d[len-1]);
    end
    check("rd_busy_end", bus.read_busy_out, 0);
  endtask

  initial begin
    int vcount;
    bus.read_start_in             = 1'b0;
    bus.read_base_in              = '0;
    bus.read_len_in               = '0;
    bus.read_next_block_valid_in  = 1'b0;
    bus.write_start_in            = 1'b0;
    bus.write_base_in             = '0;
    bus.write_len_in              = '0;
    bus.write_next_block_valid_in = 1'b0;
    bus.write_block_in            = '0;

    step();
    step();
    check("rst_rd_data", bus.read_block_out, 0);
    check("rst_rd_valid", bus.read_block_valid_out, 0);
    check("rst_rd_last", bus.read_last_block_out, 0);
    check("rst_rd_busy", bus.read_busy_out, 0);
    check("rst_rd_ovr", bus.read_overrun_out, 0);
    check("rst_wr_last", bus.write_last_out, 0);
    check("rst_wr_busy", bus.write_busy_out, 0);
    check("rst_wr_ovr", bus.write_overrun_out, 0);

    // A start held through the two edges after release must be ignored.
    rst_n_in           = 1'b1;
    bus.write_start_in = 1'b1;
    bus.write_len_in   = c_CW'(4);
    step();
    check("sync_edge1_busy", bus.write_busy_out, 0);
    step();
    check("sync_edge2_busy", bus.write_busy_out, 0);
    bus.write_start_in = 1'b0;

    write_burst(0, 4, '{32'hA, 32'hB, 32'hC, 32'hD});
    read_burst(0, 4, '{32'hA, 32'hB, 32'hC, 32'hD});

    // Wrap-around: 126,127,0,1
    write_burst(126, 4, '{32'h100, 32'h101, 32'h102, 32'h103});
    read_burst(126, 4, '{32'h100, 32'h101, 32'h102, 32'h103});
    read_burst(0, 2, '{32'h102, 32'h103, 32'h0, 32'h0});

    // Requests while idle
    bus.read_next_block_valid_in  = 1'b1;
    bus.write_next_block_valid_in = 1'b1;
    bus.write_block_in            = 32'hDEAD;
    step();
    bus.read_next_block_valid_in  = 1'b0;
    bus.write_next_block_valid_in = 1'b0;
    check("idle_rd_ovr", bus.read_overrun_out, 1);
    check("idle_wr_ovr", bus.write_overrun_out, 1);
    check("idle_wr_last", bus.write_last_out, 0);
    step();
    check("idle_rd_valid", bus.read_block_valid_out, 0);
    step();
    check("idle_rd_valid2", bus.read_block_valid_out, 0);
    check("idle_rd_ovr_sticky", bus.read_overrun_out, 1);
    read_burst(0, 1, '{32'h102, 32'h0, 32'h0, 32'h0});

    // Read-first on a same-address collision
    write_burst(5, 1, '{32'h11, 32'h0, 32'h0, 32'h0});
    bus.read_start_in  = 1'b1;
    bus.read_base_in   = c_AW'(5);
    bus.read_len_in    = c_CW'(1);
    bus.write_start_in = 1'b1;
    bus.write_base_in  = c_AW'(5);
    bus.write_len_in   = c_CW'(1);
    step();
    bus.read_start_in             = 1'b0;
    bus.write_start_in            = 1'b0;
    bus.read_next_block_valid_in  = 1'b1;
    bus.write_next_block_valid_in = 1'b1;
    bus.write_block_in            = 32'h22;
    step();
    bus.read_next_block_valid_in  = 1'b0;
    bus.write_next_block_valid_in = 1'b0;
    check("coll_wr_last", bus.write_last_out, 1);
    step();
    check("coll_valid", bus.read_block_valid_out, 1);
    check("coll_old_data", bus.read_block_out, 32'h11);
    read_burst(5, 1, '{32'h22, 32'h0, 32'h0, 32'h0});

    // Asynchronous reset with two reads in flight and a write pending
    bus.read_start_in  = 1'b1;
    bus.read_base_in   = c_AW'(0);
    bus.read_len_in    = c_CW'(4);
    bus.write_start_in = 1'b1;
    bus.write_base_in  = c_AW'(10);
    bus.write_len_in   = c_CW'(3);
    step();
    bus.read_start_in            = 1'b0;
    bus.write_start_in           = 1'b0;
    bus.read_next_block_valid_in = 1'b1;
    step();
    step();
    bus.read_next_block_valid_in = 1'b0;
    check("pre_rst_valid", bus.read_block_valid_out, 1);
    check("pre_rst_wr_busy", bus.write_busy_out, 1);
    rst_n_in = 1'b0;
    #1;
    check("async_rst_valid", bus.read_block_valid_out, 0);
    check("async_rst_data", bus.read_block_out, 0);
    check("async_rst_rd_busy", bus.read_busy_out, 0);
    check("async_rst_wr_busy", bus.write_busy_out, 0);
    step();
    rst_n_in = 1'b1;
    vcount   = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.read_block_valid_out) vcount++;
    end
    check("post_rst_stale_valid", vcount, 0);
    check("post_rst_busy", bus.read_busy_out, 0);
    read_burst(0, 1, '{32'h102, 32'h0, 32'h0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram_blocks_seq_rw.md
BRAM_BLOCKS_SEQ_RW -- requirements
Module: bram_blocks_seq_rw

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, block width in bits.
REQ-002 SHALL have parameter NUM_BLOCKS, default 128, RAM depth in blocks (>=2); AW = $clog2(NUM_BLOCKS), CW = $clog2(NUM_BLOCKS+1).
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from accepted read request to data (legal 1..4).
REQ-004 SHALL have parameter INIT_FILE, default "", RAM initialisation file; empty = contents undefined.
REQ-005 SHALL have ports: clk_in input 1 clock; rst_n_in input 1 reset. One clock; reset is asynchronous and active-low.
REQ-006 read_start_in input 1: load read base/length, begin read transaction.
REQ-007 read_base_in input AW; read_len_in input CW: start address and block count.
REQ-008 read_next_block_valid_in input 1: request next block of read transaction.
REQ-009 read_block_out output REGISTER_SIZE; read_block_valid_out output 1; read_last_block_out output 1 (marks final block, aligned with valid).
REQ-010 read_busy_out output 1; read_overrun_out output 1 (sticky).
REQ-011 write_start_in input 1; write_base_in input AW; write_len_in input CW: write transaction setup.
REQ-012 write_next_block_valid_in input 1; write_block_in input REGISTER_SIZE: write one block.
REQ-013 write_last_out output 1 (pulse); write_busy_out output 1; write_overrun_out output 1 (sticky).

Function
REQ-014 Read and write sequencers SHALL be independent FSMs, each IDLE/BUSY, sharing one dual-port RAM (port A read-only, port B write-only).
REQ-015 start with len 1..NUM_BLOCKS: IDLE or BUSY -> BUSY, address <= base, remaining <= len, sticky overrun cleared; len > NUM_BLOCKS clamped to NUM_BLOCKS; len 0: start ignored, state unchanged.
REQ-016 Each accepted next-request in BUSY SHALL use current address, then address <= (address+1) mod NUM_BLOCKS, remaining <= remaining-1.
REQ-017 Accepting the request with remaining==1 SHALL return FSM to IDLE at next edge; busy_out = (state==BUSY).
REQ-018 Next-request while IDLE SHALL not access RAM or advance address, produce no valid/write, and set overrun sticky.
REQ-019 start and next in same cycle: start wins, next ignored, overrun unchanged.
REQ-020 read_block_valid_out SHALL assert exactly READ_LATENCY cycles after each accepted read request, with the addressed data on read_block_out; back-to-back requests give back-to-back valids.
REQ-021 read_last_block_out SHALL assert with the valid of the request that had remaining==1; never otherwise.
REQ-022 read_block_out SHALL hold last read data when valid is low.
REQ-023 Write: accepted request SHALL write write_block_in at current write address at that clock edge; write_last_out pulses one cycle after the request with remaining==1.
REQ-024 Same-address read and write in one cycle SHALL return old data (read-first).
REQ-025 A read start during BUSY SHALL not cancel in-flight pipeline data; already-accepted requests still emit valid/last as computed at acceptance.

Reset
REQ-026 rst_n_in low SHALL asynchronously force both FSMs IDLE, addresses and counts 0, all outputs 0 including read_block_out, pipeline valids/lasts cleared.
REQ-027 RAM contents SHALL not be altered by reset.
REQ-028 Release of rst_n_in SHALL be synchronised; first request is accepted no earlier than the second edge after release.

Verification
REQ-029 Write start base 0 len 4, data 0xA,0xB,0xC,0xD on 4 consecutive cycles -> write_last_out one pulse after 4th; write_busy_out low thereafter.
REQ-030 Read start base 0 len 4, 4 consecutive requests, READ_LATENCY=2 -> valid on cycles 2..5 after first request, data 0xA..0xD, last only with 0xD.
REQ-031 NUM_BLOCKS=128, write/read base 126 len 4 -> addresses 126,127,0,1; data order matches.
REQ-032 Read request while IDLE -> no valid, read_overrun_out=1 until next legal start.
REQ-033 Simultaneous write and read address 5 (old 0x11, new 0x22) -> read returns 0x11; later read returns 0x22.
REQ-034 rst_n_in low mid-transaction with two reads in flight -> outputs 0 immediately, no stale valid after release, busy_out=0.
